// File: rtl/fetch_unit.sv
// Instruction fetch front end for a synchronous program memory with a fixed
// one-cycle read latency. The PC drives the memory address directly; the
// returning word lands in the output register or, if that register is full
// and stalled, in a one-entry skid buffer, so no word is lost or repeated.
// A branch flushes everything in flight and restarts fetch at the target.
// DEPTH is expected to be a power of two (targets are masked to log2(DEPTH)).
module fetch_unit #(
    parameter int N        = 16,
    parameter int DEPTH    = 1024,
    parameter int RESET_PC = 1
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] mem_addr,
    input  logic [N-1:0] mem_data,
    input  logic         halt,
    input  logic         branch_en,
    input  logic [N-1:0] branch_target,
    output logic [N-1:0] instr,
    output logic [N-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready
);

    localparam logic [N-1:0] ADDR_MASK = N'(DEPTH - 1);
    localparam logic [N-1:0] LAST_PC   = N'(DEPTH - 1);
    localparam logic [N-1:0] START_PC  = N'(RESET_PC) & ADDR_MASK;

    // Next sequential fetch address, wrapping at the top of program memory.
    function automatic logic [N-1:0] pc_inc(input logic [N-1:0] p);
        logic [N-1:0] r;
        if (p == LAST_PC) begin
            r = {N{1'b0}};
        end else begin
            r = p + {{(N-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic [N-1:0] pc_r,          pc_s;
    logic         inflight_r,    inflight_s;
    logic [N-1:0] inflight_pc_r, inflight_pc_s;
    logic         skid_valid_r,  skid_valid_s;
    logic [N-1:0] skid_data_r,   skid_data_s;
    logic [N-1:0] skid_pc_r,     skid_pc_s;
    logic         out_valid_r,   out_valid_s;
    logic [N-1:0] out_data_r,    out_data_s;
    logic [N-1:0] out_pc_r,      out_pc_s;

    logic         transfer_s;
    logic         out_free_s;
    logic         issue_s;

    assign mem_addr    = pc_r;
    assign instr       = out_data_r;
    assign instr_pc    = out_pc_r;
    assign instr_valid = out_valid_r;

    // Handshake and issue decisions for the current cycle.
    always_comb begin
        transfer_s = out_valid_r && instr_ready;
        out_free_s = !out_valid_r || transfer_s;
        issue_s    = !halt && !skid_valid_r && !(out_valid_r && !instr_ready && inflight_r);
    end

    // Next-state for PC, in-flight tracking, skid buffer and output register.
    always_comb begin
        pc_s          = pc_r;
        inflight_s    = inflight_r;
        inflight_pc_s = inflight_pc_r;
        skid_valid_s  = skid_valid_r;
        skid_data_s   = skid_data_r;
        skid_pc_s     = skid_pc_r;
        out_valid_s   = out_valid_r;
        out_data_s    = out_data_r;
        out_pc_s      = out_pc_r;

        if (branch_en) begin
            // Redirect wins over issue; everything pending is dropped.
            pc_s         = branch_target & ADDR_MASK;
            inflight_s   = 1'b0;
            skid_valid_s = 1'b0;
            out_valid_s  = 1'b0;
        end else begin
            if (issue_s) begin
                pc_s          = pc_inc(pc_r);
                inflight_s    = 1'b1;
                inflight_pc_s = pc_r;
            end else begin
                inflight_s = 1'b0;
            end

            if (out_free_s) begin
                if (skid_valid_r) begin
                    // Older skid word goes first; a new return refills the skid.
                    out_valid_s = 1'b1;
                    out_data_s  = skid_data_r;
                    out_pc_s    = skid_pc_r;
                    if (inflight_r) begin
                        skid_valid_s = 1'b1;
                        skid_data_s  = mem_data;
                        skid_pc_s    = inflight_pc_r;
                    end else begin
                        skid_valid_s = 1'b0;
                    end
                end else if (inflight_r) begin
                    out_valid_s = 1'b1;
                    out_data_s  = mem_data;
                    out_pc_s    = inflight_pc_r;
                end else begin
                    out_valid_s = 1'b0;
                end
            end else begin
                // Output stalled: park the returning word in the skid buffer.
                if (inflight_r) begin
                    skid_valid_s = 1'b1;
                    skid_data_s  = mem_data;
                    skid_pc_s    = inflight_pc_r;
                end else begin
                    skid_valid_s = skid_valid_r;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= START_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {N{1'b0}};
            skid_valid_r  <= 1'b0;
            skid_data_r   <= {N{1'b0}};
            skid_pc_r     <= {N{1'b0}};
            out_valid_r   <= 1'b0;
            out_data_r    <= {N{1'b0}};
            out_pc_r      <= {N{1'b0}};
        end else begin
            pc_r          <= pc_s;
            inflight_r    <= inflight_s;
            inflight_pc_r <= inflight_pc_s;
            skid_valid_r  <= skid_valid_s;
            skid_data_r   <= skid_data_s;
            skid_pc_r     <= skid_pc_s;
            out_valid_r   <= out_valid_s;
            out_data_r    <= out_data_s;
            out_pc_r      <= out_pc_s;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: program memory holds mem[k] = k + 0x100
// (mem[0] = 0), with hand-computed expected words and cycle positions.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        halt;
    logic        branch_en;
    logic [15:0] branch_target;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic [15:0] mem [0:1023];

    int n_cmp;
    int n_err;

    fetch_unit #(.N(16), .DEPTH(1024), .RESET_PC(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .halt          (halt),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program memory, one-cycle read latency.
    always @(posedge clk) mem_data <= mem[mem_addr[9:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_word(input string tag, input logic [15:0] v, input logic [15:0] p);
        check({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, ".instr"}, {16'd0, instr}, {16'd0, v});
        check({tag, ".pc"}, {16'd0, instr_pc}, {16'd0, p});
    endtask

    // Wait (bounded) for the next valid word, check it, let it transfer.
    task automatic next_word(input string tag, input logic [15:0] v, input logic [15:0] p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (instr_valid) begin
                expect_word(tag, v, p);
                seen = 1'b1;
            end
            step();
        end
        if (!seen) check({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int k = 0; k < 1024; k++) mem[k] = 16'h0100 + 16'(k);
        mem[0] = 16'h0000;
        rst = 1'b1;
        halt = 1'b0;
        branch_en = 1'b0;
        branch_target = 16'h0000;
        instr_ready = 1'b1;
        mem_data = 16'h0000;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst.valid", {31'd0, instr_valid}, 32'd0);
        check("rst.instr", {16'd0, instr}, 32'd0);
        check("rst.pc", {16'd0, instr_pc}, 32'd0);
        check("rst.addr", {16'd0, mem_addr}, 32'd1);
        rst = 1'b0;

        // Streaming: first word after the 2nd edge, then one per cycle.
        step();
        check("e1.valid", {31'd0, instr_valid}, 32'd0);
        step(); expect_word("e2", 16'h0101, 16'h0001);
        step(); expect_word("e3", 16'h0102, 16'h0002);
        step(); expect_word("e4", 16'h0103, 16'h0003);
        step(); expect_word("e5", 16'h0104, 16'h0004);

        // Three-cycle stall: word 4 stays put, word 5 parks in the skid.
        instr_ready = 1'b0;
        step(); expect_word("st1", 16'h0104, 16'h0004);
        step(); expect_word("st2", 16'h0104, 16'h0004);
        step(); expect_word("st3", 16'h0104, 16'h0004);
        instr_ready = 1'b1;
        next_word("rs4", 16'h0104, 16'h0004);
        next_word("rs5", 16'h0105, 16'h0005);
        next_word("rs6", 16'h0106, 16'h0006);
        next_word("rs7", 16'h0107, 16'h0007);
        expect_word("rs8", 16'h0108, 16'h0008);

        // Fill the skid, then branch to 0x200 while it is full.
        instr_ready = 1'b0;
        step(); expect_word("sk8", 16'h0108, 16'h0008);
        branch_en = 1'b1;
        branch_target = 16'h0200;
        step();
        branch_en = 1'b0;
        instr_ready = 1'b1;
        check("br1.valid", {31'd0, instr_valid}, 32'd0);
        check("br1.addr", {16'd0, mem_addr}, 32'h200);
        step();
        check("br2.valid", {31'd0, instr_valid}, 32'd0);
        step(); expect_word("br3", 16'h0300, 16'h0200);

        // Branch with high bits set (ignored) to the last address, then wrap.
        branch_en = 1'b1;
        branch_target = 16'hFFFF;
        step();
        branch_en = 1'b0;
        check("wr1.valid", {31'd0, instr_valid}, 32'd0);
        check("wr1.addr", {16'd0, mem_addr}, 32'h3FF);
        step();
        check("wr2.addr", {16'd0, mem_addr}, 32'h000);
        step(); expect_word("wr3", 16'h04FF, 16'h03FF);
        step(); expect_word("wr4", 16'h0000, 16'h0000);
        step(); expect_word("wr5", 16'h0101, 16'h0001);

        // Halt for four edges: only the in-flight word 2 is delivered.
        halt = 1'b1;
        step(); expect_word("h1", 16'h0102, 16'h0002);
        step();
        check("h2.valid", {31'd0, instr_valid}, 32'd0);
        step();
        step();
        check("h4.valid", {31'd0, instr_valid}, 32'd0);
        check("h4.addr", {16'd0, mem_addr}, 32'h3);
        halt = 1'b0;
        step();
        check("hr1.valid", {31'd0, instr_valid}, 32'd0);
        step(); expect_word("hr2", 16'h0103, 16'h0003);

        // Stall to fill the skid, then reset between edges.
        instr_ready = 1'b0;
        step(); expect_word("rs_st", 16'h0103, 16'h0003);
        #2 rst = 1'b1;
        #1;
        check("ar.valid", {31'd0, instr_valid}, 32'd0);
        check("ar.instr", {16'd0, instr}, 32'd0);
        check("ar.pc", {16'd0, instr_pc}, 32'd0);
        check("ar.addr", {16'd0, mem_addr}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        instr_ready = 1'b1;
        step();
        check("ar1.valid", {31'd0, instr_valid}, 32'd0);
        step(); expect_word("ar2", 16'h0101, 16'h0001);
        step(); expect_word("ar3", 16'h0102, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
